// File: rtl/peripheral_bus_arbiter.sv
// Round-robin arbiter that shares one peripheral register bus between two masters,
// sequencing each access as a we/oe strobe and returning a registered ack or error.
module peripheral_bus_arbiter #(
  parameter int unsigned DEVICE_COUNT   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                       clk,
  input  logic                       rst,

  input  logic                       mA_req,
  input  logic                       mA_we,
  input  logic [11:0]                mA_address,
  input  logic [3:0]                 mA_byteSelect,
  input  logic [31:0]                mA_dataWrite,
  output logic [31:0]                mA_dataRead,
  output logic                       mA_ack,
  output logic                       mA_error,

  input  logic                       mB_req,
  input  logic                       mB_we,
  input  logic [11:0]                mB_address,
  input  logic [3:0]                 mB_byteSelect,
  input  logic [31:0]                mB_dataWrite,
  output logic [31:0]                mB_dataRead,
  output logic                       mB_ack,
  output logic                       mB_error,

  output logic                       peripheralBus_we,
  output logic                       peripheralBus_oe,
  output logic [11:0]                peripheralBus_address,
  output logic [3:0]                 peripheralBus_byteSelect,
  output logic [31:0]                peripheralBus_dataWrite,

  input  logic [32*DEVICE_COUNT-1:0] device_dataRead,
  input  logic [DEVICE_COUNT-1:0]    device_requestOutput
);

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                gnt_b_q, gnt_b_d;
  logic                last_b_q, last_b_d;

  // Bus registers double as the latched request fields during ACCESS.
  logic                bus_we_q, bus_we_d;
  logic                bus_oe_q, bus_oe_d;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic [BE_W-1:0]     bus_be_q, bus_be_d;
  logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;

  logic                a_ack_q, a_ack_d, a_err_q, a_err_d;
  logic                b_ack_q, b_ack_d, b_err_q, b_err_d;
  logic [DATA_W-1:0]   a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;

  logic [DATA_W-1:0]   or_data;
  logic                resp_any;
  logic                resp_multi;
  logic                pick_b;
  logic                fin;
  logic                fin_err;
  logic [DATA_W-1:0]   fin_data;

  always_comb begin
    or_data = '0;
    for (int i = 0; i < int'(DEVICE_COUNT); i++) begin
      or_data = or_data | device_dataRead[DATA_W*i +: DATA_W];
    end
  end

  // More than one bit set iff clearing the lowest set bit leaves something.
  assign resp_any   = |device_requestOutput;
  assign resp_multi = |(device_requestOutput & (device_requestOutput - DEVICE_COUNT'(1)));
  assign pick_b     = mB_req && (!mA_req || !last_b_q);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    gnt_b_d     = gnt_b_q;
    last_b_d    = last_b_q;
    bus_we_d    = bus_we_q;
    bus_oe_d    = bus_oe_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    a_ack_d     = a_ack_q;
    a_err_d     = a_err_q;
    a_rdata_d   = a_rdata_q;
    b_ack_d     = b_ack_q;
    b_err_d     = b_err_q;
    b_rdata_d   = b_rdata_q;
    fin         = 1'b0;
    fin_err     = 1'b0;
    fin_data    = '0;

    unique case (state_q)
      IDLE: begin
        if (mA_req || mB_req) begin
          gnt_b_d     = pick_b;
          bus_we_d    = pick_b ? mB_we : mA_we;
          bus_oe_d    = pick_b ? !mB_we : !mA_we;
          bus_addr_d  = pick_b ? mB_address : mA_address;
          bus_be_d    = pick_b ? mB_byteSelect : mA_byteSelect;
          bus_wdata_d = pick_b ? mB_dataWrite : mA_dataWrite;
          cnt_d       = '0;
          state_d     = ACCESS;
        end
      end

      ACCESS: begin
        if (bus_we_q) begin
          fin = 1'b1;
        end else if (resp_multi) begin
          fin      = 1'b1;
          fin_err  = 1'b1;
          fin_data = or_data;
        end else if (resp_any) begin
          fin      = 1'b1;
          fin_data = or_data;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end

        if (fin) begin
          bus_we_d    = 1'b0;
          bus_oe_d    = 1'b0;
          bus_addr_d  = '0;
          bus_be_d    = '0;
          bus_wdata_d = '0;
          a_ack_d     = !gnt_b_q && !fin_err;
          a_err_d     = !gnt_b_q && fin_err;
          a_rdata_d   = gnt_b_q ? '0 : fin_data;
          b_ack_d     = gnt_b_q && !fin_err;
          b_err_d     = gnt_b_q && fin_err;
          b_rdata_d   = gnt_b_q ? fin_data : '0;
          state_d     = DONE;
        end
      end

      DONE: begin
        a_ack_d   = 1'b0;
        a_err_d   = 1'b0;
        a_rdata_d = '0;
        b_ack_d   = 1'b0;
        b_err_d   = 1'b0;
        b_rdata_d = '0;
        last_b_d  = gnt_b_q;
        state_d   = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      gnt_b_q     <= 1'b0;
      last_b_q    <= 1'b1;
      bus_we_q    <= 1'b0;
      bus_oe_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
      a_ack_q     <= 1'b0;
      a_err_q     <= 1'b0;
      a_rdata_q   <= '0;
      b_ack_q     <= 1'b0;
      b_err_q     <= 1'b0;
      b_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gnt_b_q     <= gnt_b_d;
      last_b_q    <= last_b_d;
      bus_we_q    <= bus_we_d;
      bus_oe_q    <= bus_oe_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      a_ack_q     <= a_ack_d;
      a_err_q     <= a_err_d;
      a_rdata_q   <= a_rdata_d;
      b_ack_q     <= b_ack_d;
      b_err_q     <= b_err_d;
      b_rdata_q   <= b_rdata_d;
    end
  end

  assign peripheralBus_we         = bus_we_q;
  assign peripheralBus_oe         = bus_oe_q;
  assign peripheralBus_address    = bus_addr_q;
  assign peripheralBus_byteSelect = bus_be_q;
  assign peripheralBus_dataWrite  = bus_wdata_q;
  assign mA_ack      = a_ack_q;
  assign mA_error    = a_err_q;
  assign mA_dataRead = a_rdata_q;
  assign mB_ack      = b_ack_q;
  assign mB_error    = b_err_q;
  assign mB_dataRead = b_rdata_q;

endmodule
